// File: rtl/bp_lce_req_stream_out_if.sv
// Bundle between the LCE request handler (message side) and the coherence-network
// request link (header channel plus data-beat channel).
interface bp_lce_req_stream_out_if #(
  parameter int unsigned hdr_width_p  = 64,
  parameter int unsigned data_width_p = 512,
  parameter int unsigned beat_width_p = 64
);
  logic [hdr_width_p-1:0]  msg_header_i;
  logic [2:0]              msg_size_i;
  logic                    msg_has_data_i;
  logic [data_width_p-1:0] msg_data_i;
  logic                    msg_v_i;
  logic                    msg_yumi_o;

  logic [hdr_width_p-1:0]  link_header_o;
  logic                    link_header_v_o;
  logic                    link_header_ready_and_i;
  logic [beat_width_p-1:0] link_data_o;
  logic                    link_data_v_o;
  logic                    link_data_last_o;
  logic                    link_data_ready_and_i;

  modport slave (
    input  msg_header_i, msg_size_i, msg_has_data_i, msg_data_i, msg_v_i,
    input  link_header_ready_and_i, link_data_ready_and_i,
    output msg_yumi_o, link_header_o, link_header_v_o,
    output link_data_o, link_data_v_o, link_data_last_o
  );

  modport master (
    output msg_header_i, msg_size_i, msg_has_data_i, msg_data_i, msg_v_i,
    output link_header_ready_and_i, link_data_ready_and_i,
    input  msg_yumi_o, link_header_o, link_header_v_o,
    input  link_data_o, link_data_v_o, link_data_last_o
  );
endinterface

// File: rtl/bp_lce_req_stream_out.sv
// Serializes one captured LCE request (header + optional payload) onto the network
// request link: header first, then payload beats, with back-to-back message support.
module bp_lce_req_stream_out #(
  parameter int unsigned hdr_width_p  = 64,
  parameter int unsigned data_width_p = 512,
  parameter int unsigned beat_width_p = 64
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  bp_lce_req_stream_out_if.slave      link_if,
  output logic                        busy_o
);

  localparam int unsigned NUM_BEATS  = data_width_p / beat_width_p;
  localparam int unsigned CNT_W      = $clog2(NUM_BEATS) + 1;
  localparam int unsigned BEAT_BYTES = beat_width_p / 8;

  typedef enum logic [1:0] {
    e_ready  = 2'd0,
    e_header = 2'd1,
    e_data   = 2'd2
  } state_e;

  state_e                  r_state;
  state_e                  w_state_next;
  logic [hdr_width_p-1:0]  r_header;
  logic [data_width_p-1:0] r_data;
  logic [2:0]              r_size;
  logic                    r_sub;
  logic [CNT_W-1:0]        r_beats;
  logic [CNT_W-1:0]        r_cnt;

  logic                    w_yumi;
  logic                    w_hdr_v;
  logic                    w_data_v;
  logic                    w_last;
  logic                    w_done;
  logic                    w_data_hs;
  logic [7:0]              w_bytes_in;
  logic [CNT_W-1:0]        w_beats_in;
  logic                    w_sub_in;
  logic [7:0]              w_mask;
  logic [beat_width_p-1:0] w_beat_sel;
  logic [beat_width_p-1:0] w_beat_rep;

  // Beat count of the incoming message; sub-beat payloads still occupy one beat
  always_comb begin
    w_bytes_in = 8'd1 << link_if.msg_size_i;
    w_sub_in   = link_if.msg_has_data_i && (32'(w_bytes_in) < BEAT_BYTES);
    if (!link_if.msg_has_data_i) begin
      w_beats_in = '0;
    end else if (32'(w_bytes_in) <= BEAT_BYTES) begin
      w_beats_in = CNT_W'(1);
    end else begin
      w_beats_in = CNT_W'(32'(w_bytes_in) / BEAT_BYTES);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= e_ready;
    end else begin
      r_state <= w_state_next;
    end
  end

  // done is not a held state: it is the cycle of the final handshake, where a new message may be taken
  always_comb begin
    w_state_next = r_state;
    w_yumi       = 1'b0;
    w_hdr_v      = 1'b0;
    w_data_v     = 1'b0;
    w_last       = 1'b0;
    w_done       = 1'b0;
    unique case (r_state)
      e_ready: begin
        w_yumi = link_if.msg_v_i;
        if (link_if.msg_v_i) w_state_next = e_header;
      end
      e_header: begin
        w_hdr_v = 1'b1;
        if (link_if.link_header_ready_and_i) begin
          if (r_beats == '0) w_done = 1'b1;
          else               w_state_next = e_data;
        end
      end
      e_data: begin
        w_data_v = 1'b1;
        w_last   = (r_cnt == r_beats - CNT_W'(1));
        if (link_if.link_data_ready_and_i && w_last) w_done = 1'b1;
      end
      default: w_state_next = e_ready;
    endcase
    if (w_done) begin
      w_yumi       = link_if.msg_v_i;
      w_state_next = link_if.msg_v_i ? e_header : e_ready;
    end
  end

  assign w_data_hs = w_data_v && link_if.link_data_ready_and_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_header <= '0;
      r_data   <= '0;
      r_size   <= '0;
      r_sub    <= 1'b0;
      r_beats  <= '0;
      r_cnt    <= '0;
    end else if (w_yumi) begin
      r_header <= link_if.msg_header_i;
      r_data   <= link_if.msg_data_i;
      r_size   <= link_if.msg_size_i;
      r_sub    <= w_sub_in;
      r_beats  <= w_beats_in;
      r_cnt    <= '0;
    end else if (w_data_hs) begin
      r_cnt    <= r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_beat_sel = '0;
    for (int unsigned b = 0; b < NUM_BEATS; b++) begin
      if (r_cnt == CNT_W'(b)) w_beat_sel = r_data[b*beat_width_p +: beat_width_p];
    end
  end

  // Sub-beat payload: byte k of the beat repeats payload byte (k mod payload bytes)
  always_comb begin
    w_mask     = (8'd1 << r_size) - 8'd1;
    w_beat_rep = '0;
    for (int unsigned k = 0; k < BEAT_BYTES; k++) begin
      for (int unsigned j = 0; j < BEAT_BYTES; j++) begin
        if ((8'(k) & w_mask) == 8'(j)) w_beat_rep[k*8 +: 8] = r_data[j*8 +: 8];
      end
    end
  end

  assign link_if.msg_yumi_o       = w_yumi & ~reset_i;
  assign link_if.link_header_o    = r_header;
  assign link_if.link_header_v_o  = w_hdr_v;
  assign link_if.link_data_o      = r_sub ? w_beat_rep : w_beat_sel;
  assign link_if.link_data_v_o    = w_data_v;
  assign link_if.link_data_last_o = w_last;
  assign busy_o                   = (r_state != e_ready);

  a_size_legal: assert property (@(posedge clk_i) disable iff (reset_i)
    (w_yumi && link_if.msg_has_data_i) |-> ((32'd8 << link_if.msg_size_i) <= data_width_p));

endmodule
